// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM encoding, build defaults and
// the address legality rule.
package dmem_responder_pkg;

  localparam int unsigned DefAddrWidth  = 6;
  localparam int unsigned DefWaitCycles = 2;
  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned CntWidth      = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } state_e;

  // A byte address is unusable if it is not word aligned or lies beyond the array.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and the data memory (slave).
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth
) ();

  logic                  Req;
  logic                  Wmem;
  logic [31:0]           Addr;
  logic [DATA_WIDTH-1:0] WData;
  logic                  Ready;
  logic [DATA_WIDTH-1:0] RData;
  logic                  Busy;
  logic                  AddrErr;

  modport master (
    output Req, Wmem, Addr, WData,
    input  Ready, RData, Busy, AddrErr
  );

  modport slave (
    input  Req, Wmem, Addr, WData,
    output Ready, RData, Busy, AddrErr
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read, contents survive reset.
module dmem_array #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge Clock) begin
    if (we) begin
      mem_q[index] <= wdata;
    end
    rdata_q <= mem_q[index];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one request, waits WAIT_CYCLES, then commits the
// store or returns load data with a one-cycle Ready pulse and an address-error flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles,
  parameter int unsigned DATA_WIDTH  = DefDataWidth
) (
  input  logic             Clock,
  input  logic             Resetn,
  dmem_responder_if.slave  bus
);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  wmem_q;
  logic                  bad_q;
  logic [ADDR_WIDTH-1:0] index_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_hold_q;

  logic                  idle;
  logic                  accept;
  logic                  commit;
  logic                  live_bad;
  logic                  cur_wmem;
  logic                  cur_bad;
  logic [ADDR_WIDTH-1:0] cur_index;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic [DATA_WIDTH-1:0] rdata_out;

  assign idle     = (state_q == StIdle);
  assign accept   = idle && bus.Req;
  assign live_bad = addr_bad(bus.Addr, ADDR_WIDTH);

  // With no wait states the access happens on the accepting edge, so it must use live inputs.
  assign cur_wmem  = idle ? bus.Wmem                     : wmem_q;
  assign cur_bad   = idle ? live_bad                     : bad_q;
  assign cur_index = idle ? bus.Addr[ADDR_WIDTH+1:2]     : index_q;
  assign cur_wdata = idle ? bus.WData                    : wdata_q;

  assign commit = ((state_q == StWait) && (cnt_q == '0)) || ((WAIT_CYCLES == 0) && accept);

  dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .Clock (Clock),
    .we    (commit && cur_wmem && !cur_bad),
    .index (cur_index),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wmem_q       <= 1'b0;
      bad_q        <= 1'b0;
      index_q      <= '0;
      wdata_q      <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wmem_q  <= bus.Wmem;
        bad_q   <= live_bad;
        index_q <= bus.Addr[ADDR_WIDTH+1:2];
        wdata_q <= bus.WData;
      end
      // Keep whatever was presented with Ready until the next completion replaces it.
      if (state_q == StResp) begin
        rdata_hold_q <= rdata_out;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Req) begin
          cnt_d   = (WAIT_CYCLES == 0) ? '0 : CntWidth'(WAIT_CYCLES - 1);
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.Ready   = 1'b0;
    bus.AddrErr = 1'b0;
    bus.Busy    = !idle;
    rdata_out   = rdata_hold_q;
    if (state_q == StResp) begin
      bus.Ready   = 1'b1;
      bus.AddrErr = bad_q;
      if (bad_q) begin
        rdata_out = '0;
      end else if (!wmem_q) begin
        rdata_out = arr_rdata;
      end
    end
  end

  assign bus.RData = rdata_out;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance under directed and random
// traffic, and a WAIT_CYCLES=0 instance streamed with Req held high.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int unsigned AW    = DefAddrWidth;
  localparam int unsigned WC    = DefWaitCycles;
  localparam int unsigned DW    = DefDataWidth;
  localparam int unsigned Depth = 1 << AW;

  typedef struct {
    bit              load;
    bit              err;
    logic [DW-1:0]   rdata;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst0_n = 1'b0;

  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_WIDTH(DW)) bus  ();
  dmem_responder_if #(.DATA_WIDTH(DW)) bus0 ();

  dmem_responder #(
    .ADDR_WIDTH  (AW),
    .WAIT_CYCLES (WC),
    .DATA_WIDTH  (DW)
  ) u_dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  dmem_responder #(
    .ADDR_WIDTH  (AW),
    .WAIT_CYCLES (0),
    .DATA_WIDTH  (DW)
  ) u_dut0 (
    .Clock  (clk),
    .Resetn (rst0_n),
    .bus    (bus0)
  );

  exp_t          exp_q[$];
  exp_t          exp0_q[$];
  logic [DW-1:0] model_mem  [Depth];
  logic [DW-1:0] model_mem0 [Depth];
  logic [DW-1:0] last_rd  = '0;
  logic [DW-1:0] last_rd0 = '0;
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * Depth);
  endfunction

  // Reference behaviour: what the response to one request must be, given memory history.
  task automatic model_step(input bit which, input bit wmem, input logic [31:0] a,
                            input logic [DW-1:0] wd);
    exp_t e;
    int   idx;
    e.load  = !wmem;
    e.err   = is_bad(a);
    e.rdata = '0;
    idx     = int'(a / 4) % Depth;
    if (!e.err) begin
      if (which) begin
        if (wmem) model_mem0[idx] = wd;
        else      e.rdata = model_mem0[idx];
      end else begin
        if (wmem) model_mem[idx] = wd;
        else      e.rdata = model_mem[idx];
      end
    end
    if (which) exp0_q.push_back(e);
    else       exp_q.push_back(e);
  endtask

  task automatic mon_step(input bit which, input logic rstn, input logic ready, input logic err,
                          input logic [DW-1:0] rd);
    exp_t          e;
    logic [DW-1:0] last;
    int            qsize;
    string         tag;
    if (!rstn) return;
    tag   = which ? "dut0_" : "dut_";
    last  = which ? last_rd0 : last_rd;
    qsize = which ? exp0_q.size() : exp_q.size();
    if (ready && qsize == 0) begin
      check({tag, "ready_unexpected"}, ready, 1'b0);
    end else if (ready) begin
      if (which) e = exp0_q.pop_front();
      else       e = exp_q.pop_front();
      check({tag, "addr_err"}, err, e.err);
      if (e.load || e.err) last = e.rdata;
      check({tag, "rdata_resp"}, rd, last);
    end else begin
      check({tag, "addr_err_idle"}, err, 1'b0);
      check({tag, "rdata_hold"}, rd, last);
    end
    if (which) last_rd0 = last;
    else       last_rd  = last;
  endtask

  always @(posedge clk) begin
    #2;
    mon_step(1'b0, rst_n, bus.Ready, bus.AddrErr, bus.RData);
  end

  always @(posedge clk) begin
    #2;
    mon_step(1'b1, rst0_n, bus0.Ready, bus0.AddrErr, bus0.RData);
  end

  // One request on the WAIT_CYCLES instance; inputs are scrambled while it is in flight.
  task automatic req_main(input bit wmem, input logic [31:0] a, input logic [DW-1:0] wd);
    int lat;
    bit got;
    @(negedge clk);
    check("busy_before", bus.Busy, 1'b0);
    bus.Req   = 1'b1;
    bus.Wmem  = wmem;
    bus.Addr  = a;
    bus.WData = wd;
    model_step(1'b0, wmem, a, wd);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      check("busy_inflight", bus.Busy, 1'b1);
      if (bus.Ready) begin
        got = 1'b1;
        lat = k;
      end
      bus.Wmem  = 1'($urandom);
      bus.Addr  = $urandom;
      bus.WData = $urandom;
    end
    bus.Req = 1'b0;
    check("latency", lat, WC + 1);
    @(negedge clk);
    check("busy_after", bus.Busy, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    logic [31:0] a = 32'($urandom_range(0, Depth - 1)) << 2;
    if (r == 0)      a = a | 32'($urandom_range(1, 3));
    else if (r == 1) a = a | (32'h1 << $urandom_range(AW + 2, 31));
    return a;
  endfunction

  // Back-to-back traffic on the zero-wait instance with Req never dropped between requests.
  task automatic stream0(input int n, input bit init_fill);
    bit            w;
    logic [31:0]   a;
    logic [DW-1:0] d;
    @(negedge clk);
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check("dut0_ready_resp", bus0.Ready, 1'b1);
        check("dut0_busy_resp", bus0.Busy, 1'b1);
      end
      if (i < n) begin
        w = init_fill ? 1'b1 : 1'($urandom);
        a = init_fill ? 32'(i * 4) : rand_addr();
        d = $urandom;
        bus0.Req   = 1'b1;
        bus0.Wmem  = w;
        bus0.Addr  = a;
        bus0.WData = d;
        model_step(1'b1, w, a, d);
      end else begin
        bus0.Req = 1'b0;
      end
      if (i > 0) begin
        @(negedge clk);
        check("dut0_ready_idle", bus0.Ready, 1'b0);
        check("dut0_busy_idle", bus0.Busy, 1'b0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Req    = 1'b0;
    bus.Wmem   = 1'b0;
    bus.Addr   = '0;
    bus.WData  = '0;
    bus0.Req   = 1'b0;
    bus0.Wmem  = 1'b0;
    bus0.Addr  = '0;
    bus0.WData = '0;

    repeat (3) @(negedge clk);
    check("reset_ready", bus.Ready, 1'b0);
    check("reset_busy", bus.Busy, 1'b0);
    check("reset_addr_err", bus.AddrErr, 1'b0);
    check("reset_rdata", bus.RData, '0);
    check("dut0_reset_ready", bus0.Ready, 1'b0);
    check("dut0_reset_busy", bus0.Busy, 1'b0);
    check("dut0_reset_rdata", bus0.RData, '0);
    rst_n  = 1'b1;
    rst0_n = 1'b1;

    for (int i = 0; i < int'(Depth); i++) req_main(1'b1, 32'(i * 4), $urandom);

    req_main(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    req_main(1'b0, 32'h0000_0010, '0);
    req_main(1'b1, 32'h0000_0014, 32'h0BAD_CAFE);
    req_main(1'b1, 32'h0000_0012, 32'h1234_5678);
    req_main(1'b0, 32'h0000_0010, '0);
    req_main(1'b0, 32'h0000_0100, '0);

    // Reset while a store is waiting: it must vanish without a Ready.
    @(negedge clk);
    bus.Req   = 1'b1;
    bus.Wmem  = 1'b1;
    bus.Addr  = 32'h0000_0020;
    bus.WData = 32'hCAFE_F00D;
    @(negedge clk);
    check("busy_wait", bus.Busy, 1'b1);
    rst_n   = 1'b0;
    last_rd = '0;
    #1;
    check("busy_mid_reset", bus.Busy, 1'b0);
    check("ready_mid_reset", bus.Ready, 1'b0);
    bus.Req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    req_main(1'b0, 32'h0000_0020, '0);

    for (int i = 0; i < 150; i++) req_main(1'($urandom), rand_addr(), $urandom);

    stream0(int'(Depth), 1'b1);
    stream0(3, 1'b0);
    stream0(40, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("dut0_queue_drained", exp0_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
